// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: drains the rts/rtr pixel stream into framebuffer RAM,
// tracking raster position and pulsing frame_done after each frame.
module fb_pixel_writer #(
    parameter int DATA_WIDTH = 12,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_rts,
    output logic                  in_rtr,
    output logic                  in_xfc,
    input  logic                  mem_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [15:0]           x_pos,
    output logic [15:0]           y_pos,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] X_LAST = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

    state_t                  state_q;
    logic [15:0]             x_q, x_d;
    logic [15:0]             y_q, y_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   maddr_q;
    logic [DATA_WIDTH-1:0]   mdata_q;
    logic                    done_q;
    logic                    last_px;

    // Backpressure from the RAM gates acceptance in the same cycle.
    assign in_rtr = (state_q == S_RUN) && !mem_busy;
    assign in_xfc = in_rts && in_rtr;

    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_data   = mdata_q;
    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign busy       = (state_q == S_RUN);
    assign frame_done = done_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (in_xfc) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    assign last_px = in_xfc && (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= in_xfc;
            done_q <= 1'b0;
            if (in_xfc) begin
                maddr_q <= addr_q;
                mdata_q <= in_data;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= BASE_ADDR;
                    end
                end
                S_RUN: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    addr_q <= addr_d;
                    // abort outranks completion of the final pixel
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (last_px) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed testbench for fb_pixel_writer: small 4x2 frame at base 0x10,
// plus a second instance exercising address wraparound.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst = 1'b1, a_start = 1'b0, a_abort = 1'b0;
    logic [11:0] a_in_data = '0;
    logic        a_in_rts = 1'b0, a_mem_busy = 1'b0;
    logic        a_in_rtr, a_in_xfc, a_mem_we, a_busy, a_frame_done;
    logic [14:0] a_mem_addr;
    logic [11:0] a_mem_data;
    logic [15:0] a_x_pos, a_y_pos;

    logic        b_rst = 1'b1, b_start = 1'b0, b_abort = 1'b0;
    logic [11:0] b_in_data = '0;
    logic        b_in_rts = 1'b0, b_mem_busy = 1'b0;
    logic        b_in_rtr, b_in_xfc, b_mem_we, b_busy, b_frame_done;
    logic [2:0]  b_mem_addr;
    logic [11:0] b_mem_data;
    logic [15:0] b_x_pos, b_y_pos;

    fb_pixel_writer #(
        .DATA_WIDTH(12), .H_RES(4), .V_RES(2),
        .ADDR_WIDTH(15), .BASE_ADDR(15'h10)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
        .in_data(a_in_data), .in_rts(a_in_rts), .in_rtr(a_in_rtr),
        .in_xfc(a_in_xfc), .mem_busy(a_mem_busy), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .x_pos(a_x_pos), .y_pos(a_y_pos), .busy(a_busy),
        .frame_done(a_frame_done)
    );

    fb_pixel_writer #(
        .DATA_WIDTH(12), .H_RES(4), .V_RES(1),
        .ADDR_WIDTH(3), .BASE_ADDR(3'd6)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
        .in_data(b_in_data), .in_rts(b_in_rts), .in_rtr(b_in_rtr),
        .in_xfc(b_in_xfc), .mem_busy(b_mem_busy), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .x_pos(b_x_pos), .y_pos(b_y_pos), .busy(b_busy),
        .frame_done(b_frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        checks++;
        if (a_mem_we !== 1'b0 || a_mem_addr !== 15'h0 || a_mem_data !== 12'h0) begin
            errors++;
            $display("FAIL reset_mem we=%b addr=%h data=%h required 0 0 0",
                     a_mem_we, a_mem_addr, a_mem_data);
        end
        checks++;
        if (a_busy !== 1'b0 || a_frame_done !== 1'b0 || a_in_rtr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy=%b done=%b rtr=%b required 0 0 0",
                     a_busy, a_frame_done, a_in_rtr);
        end
        checks++;
        if (a_x_pos !== 16'd0 || a_y_pos !== 16'd0) begin
            errors++;
            $display("FAIL reset_pos x=%0d y=%0d required 0 0", a_x_pos, a_y_pos);
        end
    endtask

    task automatic test_basic_frame();
        pulse_start_a();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b required 1", a_busy);
        end
        for (int i = 0; i < 8; i++) begin
            a_in_rts  = 1'b1;
            a_in_data = 12'(i + 1);
            #1;
            checks++;
            if (a_in_xfc !== 1'b1) begin
                errors++;
                $display("FAIL basic_xfc px%0d got %b required 1", i, a_in_xfc);
            end
            step();
            checks++;
            if (a_mem_we !== 1'b1 || a_mem_addr !== 15'(16 + i) ||
                a_mem_data !== 12'(i + 1)) begin
                errors++;
                $display("FAIL basic_write px%0d we=%b addr=%h data=%h required 1 %h %h",
                         i, a_mem_we, a_mem_addr, a_mem_data, 16 + i, i + 1);
            end
            checks++;
            if (a_frame_done !== (i == 7)) begin
                errors++;
                $display("FAIL basic_done px%0d got %b required %b",
                         i, a_frame_done, i == 7);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (a_x_pos !== 16'(i - 3) || a_y_pos !== 16'd1) begin
                    errors++;
                    $display("FAIL line_wrap px%0d x=%0d y=%0d required %0d 1",
                             i, a_x_pos, a_y_pos, i - 3);
                end
            end
        end
        a_in_rts = 1'b1;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_in_rtr !== 1'b0 || a_x_pos !== 16'd0 ||
            a_y_pos !== 16'd0) begin
            errors++;
            $display("FAIL basic_end busy=%b rtr=%b x=%0d y=%0d required 0 0 0 0",
                     a_busy, a_in_rtr, a_x_pos, a_y_pos);
        end
        step();
        a_in_rts = 1'b0;
        checks++;
        if (a_frame_done !== 1'b0 || a_mem_we !== 1'b0 || a_mem_addr !== 15'h17) begin
            errors++;
            $display("FAIL basic_after done=%b we=%b addr=%h required 0 0 17",
                     a_frame_done, a_mem_we, a_mem_addr);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int wr;
        logic exp_x;
        n  = 0;
        wr = 0;
        pulse_start_a();
        for (int c = 0; c < 16; c++) begin
            a_mem_busy = (c >= 3 && c <= 5);
            a_in_rts   = (n < 8);
            a_in_data  = 12'(12'h100 + n);
            #1;
            exp_x = a_in_rts && !a_mem_busy;
            if (n < 8) begin
                checks++;
                if (a_in_rtr !== !a_mem_busy) begin
                    errors++;
                    $display("FAIL bp_rtr c%0d got %b required %b",
                             c, a_in_rtr, !a_mem_busy);
                end
            end
            checks++;
            if (a_in_xfc !== exp_x) begin
                errors++;
                $display("FAIL bp_xfc c%0d got %b required %b", c, a_in_xfc, exp_x);
            end
            step();
            if (a_mem_we === 1'b1) wr++;
            checks++;
            if (a_mem_we !== exp_x) begin
                errors++;
                $display("FAIL bp_we c%0d got %b required %b", c, a_mem_we, exp_x);
            end
            if (exp_x) begin
                checks++;
                if (a_mem_addr !== 15'(16 + n) || a_mem_data !== 12'(12'h100 + n)) begin
                    errors++;
                    $display("FAIL bp_write n%0d addr=%h data=%h required %h %h",
                             n, a_mem_addr, a_mem_data, 16 + n, 12'h100 + n);
                end
                n++;
            end
        end
        a_mem_busy = 1'b0;
        a_in_rts   = 1'b0;
        checks++;
        if (wr !== 8) begin
            errors++;
            $display("FAIL bp_total got %0d required 8", wr);
        end
    endtask

    task automatic test_bursty();
        int n;
        int wr;
        logic exp_x;
        n  = 0;
        wr = 0;
        pulse_start_a();
        for (int c = 0; c < 20; c++) begin
            a_in_rts  = (c % 2 == 0) && (n < 8);
            a_in_data = 12'(12'h200 + n);
            #1;
            exp_x = a_in_rts;
            step();
            if (a_mem_we === 1'b1) wr++;
            checks++;
            if (a_mem_we !== exp_x) begin
                errors++;
                $display("FAIL burst_we c%0d got %b required %b", c, a_mem_we, exp_x);
            end
            if (exp_x) begin
                checks++;
                if (a_mem_addr !== 15'(16 + n) || a_mem_data !== 12'(12'h200 + n)) begin
                    errors++;
                    $display("FAIL burst_write n%0d addr=%h data=%h required %h %h",
                             n, a_mem_addr, a_mem_data, 16 + n, 12'h200 + n);
                end
                n++;
            end
            checks++;
            if (a_x_pos !== 16'(n % 4) || a_y_pos !== 16'((n / 4) % 2)) begin
                errors++;
                $display("FAIL burst_pos c%0d x=%0d y=%0d required %0d %0d",
                         c, a_x_pos, a_y_pos, n % 4, (n / 4) % 2);
            end
        end
        a_in_rts = 1'b0;
        checks++;
        if (wr !== 8) begin
            errors++;
            $display("FAIL burst_total got %0d required 8", wr);
        end
    endtask

    task automatic test_abort();
        pulse_start_a();
        for (int i = 0; i < 3; i++) begin
            a_in_rts  = 1'b1;
            a_in_data = 12'(12'h300 + i);
            a_abort   = (i == 2);
            step();
        end
        a_abort = 1'b0;
        checks++;
        if (a_mem_we !== 1'b1 || a_mem_addr !== 15'h12 || a_mem_data !== 12'h302) begin
            errors++;
            $display("FAIL abort_write we=%b addr=%h data=%h required 1 12 302",
                     a_mem_we, a_mem_addr, a_mem_data);
        end
        checks++;
        if (a_frame_done !== 1'b0 || a_busy !== 1'b0 || a_in_rtr !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle done=%b busy=%b rtr=%b required 0 0 0",
                     a_frame_done, a_busy, a_in_rtr);
        end
        step();
        checks++;
        if (a_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_nowrite got %b required 0", a_mem_we);
        end
        a_in_rts = 1'b0;
        a_start  = 1'b1;
        a_abort  = 1'b1;
        step();
        a_start = 1'b0;
        a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_x_pos !== 16'd0 || a_y_pos !== 16'd0) begin
            errors++;
            $display("FAIL restart busy=%b x=%0d y=%0d required 1 0 0",
                     a_busy, a_x_pos, a_y_pos);
        end
        for (int i = 0; i < 8; i++) begin
            a_in_rts  = 1'b1;
            a_in_data = 12'(12'h3A0 + i);
            a_abort   = (i == 7);
            step();
            if (i == 0) begin
                checks++;
                if (a_mem_addr !== 15'h10 || a_mem_data !== 12'h3A0) begin
                    errors++;
                    $display("FAIL restart_addr addr=%h data=%h required 10 3a0",
                             a_mem_addr, a_mem_data);
                end
            end
        end
        a_abort  = 1'b0;
        a_in_rts = 1'b0;
        checks++;
        if (a_mem_we !== 1'b1 || a_mem_addr !== 15'h17 || a_frame_done !== 1'b0 ||
            a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_last we=%b addr=%h done=%b busy=%b required 1 17 0 0",
                     a_mem_we, a_mem_addr, a_frame_done, a_busy);
        end
        step();
        checks++;
        if (a_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_done got %b required 0", a_frame_done);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start_a();
        for (int i = 0; i < 2; i++) begin
            a_in_rts  = 1'b1;
            a_in_data = 12'(12'h400 + i);
            step();
        end
        a_in_data = 12'h4FF;
        a_rst     = 1'b1;
        #1;
        checks++;
        if (a_in_xfc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_xfc got %b required 1", a_in_xfc);
        end
        step();
        a_rst    = 1'b0;
        a_in_rts = 1'b0;
        #1;
        checks++;
        if (a_mem_we !== 1'b0 || a_mem_addr !== 15'h0 || a_mem_data !== 12'h0 ||
            a_busy !== 1'b0 || a_frame_done !== 1'b0 || a_x_pos !== 16'd0 ||
            a_y_pos !== 16'd0) begin
            errors++;
            $display("FAIL rstmid we=%b addr=%h data=%h busy=%b done=%b x=%0d y=%0d required all 0",
                     a_mem_we, a_mem_addr, a_mem_data, a_busy, a_frame_done,
                     a_x_pos, a_y_pos);
        end
    endtask

    task automatic test_addr_wrap();
        logic [2:0] exp_addr [4];
        exp_addr[0] = 3'd6;
        exp_addr[1] = 3'd7;
        exp_addr[2] = 3'd0;
        exp_addr[3] = 3'd1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in_rts  = 1'b1;
            b_in_data = 12'(12'h500 + i);
            step();
            checks++;
            if (b_mem_we !== 1'b1 || b_mem_addr !== exp_addr[i] ||
                b_mem_data !== 12'(12'h500 + i) || b_frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL wrap px%0d we=%b addr=%0d data=%h done=%b required 1 %0d %h %b",
                         i, b_mem_we, b_mem_addr, b_mem_data, b_frame_done,
                         exp_addr[i], 12'h500 + i, i == 3);
            end
        end
        b_in_rts = 1'b0;
        step();
        checks++;
        if (b_busy !== 1'b0 || b_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end busy=%b we=%b required 0 0", b_busy, b_mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_bursty();
        test_abort();
        test_reset_mid();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
